// File: rtl/alu_if.sv
// Operand/result bundle between the register-file read ports, the ALU and
// the write-back/branch logic.
interface alu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OPRN_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] OP1;
    logic [DATA_WIDTH-1:0] OP2;
    logic [OPRN_WIDTH-1:0] OPRN;
    logic [DATA_WIDTH-1:0] OUT;
    logic                  ZERO;

    modport master (
        output OP1,
        output OP2,
        output OPRN,
        input  OUT,
        input  ZERO
    );

    modport slave (
        input  OP1,
        input  OP2,
        input  OPRN,
        output OUT,
        output ZERO
    );
endinterface

// File: rtl/alu.sv
// Registered unsigned ALU: nine operations selected by OPRN, result and zero
// flag captured together on the rising edge of CLK.
module alu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OPRN_WIDTH = 6
) (
    input  logic  CLK,
    input  logic  RST,
    alu_if.slave  bus
);
    localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_zero;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_zero;

    // Shifts use the full-width OP2; amounts >= DATA_WIDTH zero-fill entirely.
    always_comb begin
        w_result = '0;
        case (bus.OPRN)
            OP_ADD:  w_result = bus.OP1 + bus.OP2;
            OP_SUB:  w_result = bus.OP1 - bus.OP2;
            OP_MUL:  w_result = bus.OP1 * bus.OP2;
            OP_SRL:  w_result = bus.OP1 >> bus.OP2;
            OP_SLL:  w_result = bus.OP1 << bus.OP2;
            OP_AND:  w_result = bus.OP1 & bus.OP2;
            OP_OR:   w_result = bus.OP1 | bus.OP2;
            OP_NOR:  w_result = ~(bus.OP1 | bus.OP2);
            OP_SLT:  w_result = {{(DATA_WIDTH-1){1'b0}}, (bus.OP1 < bus.OP2)};
            default: w_result = '0;
        endcase
    end

    assign w_zero = (w_result == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out  <= '0;
            r_zero <= 1'b1;
        end else begin
            r_out  <= w_result;
            r_zero <= w_zero;
        end
    end

    assign bus.OUT  = r_out;
    assign bus.ZERO = r_zero;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/latency sequences
// and randomized operations against an arithmetic reference model.
module tb_alu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    alu_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) bus ();

    alu #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  oprn;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    // Reference: arithmetic on 64-bit values reduced modulo 2^32.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
        longint unsigned la, lb, m;
        la = 64'(a);
        lb = 64'(b);
        m  = 64'h1_0000_0000;
        case (op)
            6'h01: return 32'((la + lb) % m);
            6'h02: return 32'((la + m - lb) % m);
            6'h03: return 32'((la * lb) % m);
            6'h04: return (lb >= 32) ? 32'd0 : 32'(la / (64'd1 << lb));
            6'h05: return (lb >= 32) ? 32'd0 : 32'((la * (64'd1 << lb)) % m);
            6'h06: return a & b;
            6'h07: return a | b;
            6'h08: return ~(a | b);
            6'h09: return (la < lb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        @(negedge clk);
        bus.OP1  = a;
        bus.OP2  = b;
        bus.OPRN = op;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"add15_3",   32'd15, 32'd3,  6'h01, 32'd18, 1'b0});
        vecs.push_back('{"add15_5",   32'd15, 32'd5,  6'h01, 32'd20, 1'b0});
        vecs.push_back('{"sub15_5",   32'd15, 32'd5,  6'h02, 32'd10, 1'b0});
        vecs.push_back('{"mul15_7",   32'd15, 32'd7,  6'h03, 32'd105, 1'b0});
        vecs.push_back('{"sub5_15",   32'd5,  32'd15, 6'h02, 32'hFFFFFFF6, 1'b0});
        vecs.push_back('{"addwrap",   32'hFFFFFFFF, 32'd1, 6'h01, 32'd0, 1'b1});
        vecs.push_back('{"srl15_2",   32'd15, 32'd2,  6'h04, 32'd3, 1'b0});
        vecs.push_back('{"sll15_3",   32'd15, 32'd3,  6'h05, 32'd120, 1'b0});
        vecs.push_back('{"sll15_32",  32'd15, 32'd32, 6'h05, 32'd0, 1'b1});
        vecs.push_back('{"srlmsb31",  32'h80000000, 32'd31, 6'h04, 32'd1, 1'b0});
        vecs.push_back('{"srlbig",    32'hFFFFFFFF, 32'h100, 6'h04, 32'd0, 1'b1});
        vecs.push_back('{"and15_15",  32'd15, 32'd15, 6'h06, 32'd15, 1'b0});
        vecs.push_back('{"and15_9",   32'd15, 32'd9,  6'h06, 32'd9, 1'b0});
        vecs.push_back('{"or15_14",   32'd15, 32'd14, 6'h07, 32'd15, 1'b0});
        vecs.push_back('{"or15_15",   32'd15, 32'd15, 6'h07, 32'd15, 1'b0});
        vecs.push_back('{"nor15_15",  32'd15, 32'd15, 6'h08, 32'hFFFFFFF0, 1'b0});
        vecs.push_back('{"nor15_0",   32'd15, 32'd0,  6'h08, 32'hFFFFFFF0, 1'b0});
        vecs.push_back('{"slt15_14",  32'd15, 32'd14, 6'h09, 32'd0, 1'b1});
        vecs.push_back('{"slt15_15",  32'd15, 32'd15, 6'h09, 32'd0, 1'b1});
        vecs.push_back('{"slt15_16",  32'd15, 32'd16, 6'h09, 32'd1, 1'b0});
        vecs.push_back('{"sltunsig",  32'd1, 32'hFFFFFFFF, 6'h09, 32'd1, 1'b0});
        vecs.push_back('{"illegal00", 32'd15, 32'd3,  6'h00, 32'd0, 1'b1});
        vecs.push_back('{"illegal0A", 32'd15, 32'd3,  6'h0A, 32'd0, 1'b1});
        vecs.push_back('{"illegal3F", 32'd15, 32'd3,  6'h3F, 32'd0, 1'b1});

        bus.OP1  = 32'd15;
        bus.OP2  = 32'd3;
        bus.OPRN = 6'h01;

        // Reset held across clock edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",  bus.OUT, 32'd0);
        check("rst_zero", 32'(bus.ZERO), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_out",  bus.OUT, 32'd18);
        check("first_zero", 32'(bus.ZERO), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op1, vecs[i].op2, vecs[i].oprn);
            check({vecs[i].name, "_out"},  bus.OUT, vecs[i].exp_out);
            check({vecs[i].name, "_zero"}, 32'(bus.ZERO), 32'(vecs[i].exp_zero));
        end

        // Mid-cycle input change must not reach OUT before the next edge.
        run_op(32'd15, 32'd5, 6'h01);
        check("lat_before", bus.OUT, 32'd20);
        #2;
        bus.OP1 = 32'd100; bus.OP2 = 32'd1; bus.OPRN = 6'h02;
        #1;
        check("lat_hold", bus.OUT, 32'd20);
        @(posedge clk);
        #1;
        check("lat_after", bus.OUT, 32'd99);

        // Asynchronous reset between edges, pending result discarded.
        #2;
        rst = 1'b0;
        #1;
        check("arst_out",  bus.OUT, 32'd0);
        check("arst_zero", 32'(bus.ZERO), 32'd1);
        @(posedge clk);
        #1;
        check("arst_hold", bus.OUT, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release", bus.OUT, 32'd99);

        // Randomized operations, biased toward small shift amounts.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b, e;
            logic [5:0]  op;
            a  = $urandom;
            b  = $urandom;
            op = 6'($urandom_range(0, 12));
            if (i % 5 == 0) op = 6'($urandom_range(0, 63));
            if ((op == 6'h04 || op == 6'h05) && (i % 3 != 0)) b = 32'($urandom_range(0, 40));
            if (i % 17 == 0) b = a;
            run_op(a, b, op);
            e = model(a, b, op);
            check($sformatf("rnd%0d_op%0h_out", i, op), bus.OUT, e);
            check($sformatf("rnd%0d_zero", i), 32'(bus.ZERO), (e == 32'd0) ? 32'd1 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
